// File: rtl/yuyin_frame_tx.sv
// yuyin_frame_tx: builds the six-byte voice-module play frame and streams it into a UART byte transmitter
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   play_req_i   one-cycle request to play play_addr_i
//   play_addr_i  voice address, sampled with play_req_i
//   alarm_req_i  one-cycle request to play ALARM_ADDR
//   tx_done_i    one-cycle pulse from the UART when the current byte's stop bit ends
//   tx_byte_o    byte presented to the UART, held until the next load
//   tx_start_o   one-cycle strobe to send tx_byte_o
//   busy_o       high from request acceptance until the inter-frame gap expires
//   frame_done_o one-cycle pulse when the sixth byte completes
module yuyin_frame_tx #(
    parameter logic [6:0] ALARM_ADDR = 7'd99,
    parameter int         GAP_CYCLES = 500000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       play_req_i,
    input  logic [6:0] play_addr_i,
    input  logic       alarm_req_i,
    input  logic       tx_done_i,
    output logic [7:0] tx_byte_o,
    output logic       tx_start_o,
    output logic       busy_o,
    output logic       frame_done_o
);
    localparam int CW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [6:0]      addr_q, addr_d;
    logic            pend_q, pend_d;
    logic [7:0]      byte_q, byte_d;
    logic            fd_q, fd_d;

    // B5 is the mod-256 sum of all preceding bytes; the fixed bytes sum to 0xB3.
    function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [6:0] a);
        case (i)
            3'd0:    frame_byte = 8'hAA;
            3'd1:    frame_byte = 8'h07;
            3'd2:    frame_byte = 8'h02;
            3'd3:    frame_byte = 8'h00;
            3'd4:    frame_byte = {1'b0, a};
            default: frame_byte = 8'hB3 + {1'b0, a};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        byte_d  = byte_q;
        fd_d    = 1'b0;
        // Alarms arriving while busy collapse into one pending flag.
        pend_d  = pend_q | (alarm_req_i && state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (alarm_req_i || pend_q || play_req_i) begin
                    addr_d  = (alarm_req_i || pend_q) ? ALARM_ADDR : play_addr_i;
                    idx_d   = 3'd0;
                    pend_d  = 1'b0;
                    byte_d  = 8'hAA;
                    state_d = SEND;
                end
            end
            SEND: state_d = WAIT;
            WAIT: begin
                if (tx_done_i) begin
                    if (idx_q == 3'd5) begin
                        fd_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = GAP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        byte_d  = frame_byte(idx_q + 3'd1, addr_q);
                        state_d = SEND;
                    end
                end
            end
            GAP: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == GAP_LAST) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            pend_q  <= 1'b0;
            byte_q  <= '0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            byte_q  <= byte_d;
            fd_q    <= fd_d;
        end
    end

    assign tx_byte_o    = byte_q;
    assign tx_start_o   = (state_q == SEND);
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = fd_q;
endmodule

// File: doc/yuyin_frame_tx.md
# yuyin_frame_tx

Builds the fixed six-byte play command frame for the voice module and streams it byte by byte into the UART byte transmitter that drives `serial_data_tx`. It sits directly upstream of that transmitter. It accepts a play request (voice address from the key/location logic) or an alarm request (fixed alarm clip). It enforces an idle gap between frames so the voice module is never overrun.

## Interface
- `ALARM_ADDR`, 7'd99, voice address played on an alarm request.
- `GAP_CYCLES`, 500000, idle clocks after the last byte's `tx_done` before the next frame may start (10 ms at 50 MHz); must be ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `play_req`  in  1  one-cycle request to play `play_addr`.
- `play_addr`  in  7  voice address, sampled in the same cycle as `play_req`.
- `alarm_req`  in  1  one-cycle request to play `ALARM_ADDR`.
- `tx_done`  in  1  one-cycle pulse from the UART byte transmitter when the stop bit of the current byte finishes.
- `tx_byte`  out  8  byte presented to the UART; valid while `tx_start` is high, held until the next load.
- `tx_start`  out  1  one-cycle strobe to send `tx_byte`.
- `busy`  out  1  high from request acceptance until the gap expires.
- `frame_done`  out  1  one-cycle pulse when the sixth byte's `tx_done` arrives.

## Operation
- Frame bytes B0..B5:
  - B0 = 0xAA, B1 = 0x07, B2 = 0x02, B3 = 0x00.
  - B4 = {1'b0, addr}.
  - B5 = (B0+B1+B2+B3+B4) mod 256, which equals (0xB3 + B4) mod 256.
- The checksum is computed from the latched address. It does not depend on the input after acceptance.
- FSM states: IDLE, SEND, WAIT, GAP.
  - IDLE: if `alarm_req`, latch `ALARM_ADDR`; else if `play_req`, latch `play_addr`. Set byte index = 0 and go to SEND. Otherwise stay.
  - SEND: drive `tx_start` = 1 and `tx_byte` = B[index] for exactly one cycle, then go to WAIT.
  - WAIT: on `tx_done`, if index = 5, pulse `frame_done` and go to GAP with the gap counter = 0; otherwise index += 1 and go to SEND.
  - GAP: increment the counter each cycle. When the counter reaches `GAP_CYCLES`-1, go to IDLE.
- Counter width is $clog2(GAP_CYCLES+1); the index is 3 bits.
- Requests that arrive while not in IDLE:
  - `play_req`: dropped; there is no queue.
  - `alarm_req`: sets a single pending flag.
- In IDLE, a set pending flag is treated as an alarm request and is cleared on acceptance.
- Simultaneous `play_req` and `alarm_req` in IDLE: the alarm wins and the play request is dropped.
- An alarm request arriving while the pending flag is already set merges with it; at most one extra alarm frame is sent.
- `tx_done` outside WAIT is ignored.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: `tx_byte` = 0x00, `tx_start` = 0, `busy` = 0, `frame_done` = 0. State = IDLE, index = 0, gap counter = 0, pending = 0.
- Reset mid-frame aborts immediately: no further `tx_start`, and the pending alarm is lost.
- A request sampled at clock edge k:
  - `busy` = 1 and state = SEND after edge k.
  - `tx_start` = 1 with B0 during cycle k+1.
- `tx_done` sampled at edge m (index < 5): `tx_start` for the next byte is high during cycle m+1. Byte-to-byte overhead is therefore one clock beyond the UART byte time.
- `frame_done` and the entry to GAP happen at the same edge as the sixth `tx_done`.
- `busy` stays high for exactly `GAP_CYCLES` cycles after that edge.
- A request or pending alarm is first accepted on the edge after `busy` falls.
- `tx_start` is never high on two consecutive cycles, and never high outside SEND.

## Test plan
- Reset, then `play_req` with `play_addr` = 5 → `tx_start` strobes carry 0xAA, 0x07, 0x02, 0x00, 0x05, 0xB8 in order. `frame_done` fires once, and `busy` falls exactly `GAP_CYCLES` clocks after the sixth `tx_done`.
- `alarm_req` alone with the default `ALARM_ADDR` → B4 = 0x63, B5 = 0x16. `play_addr` = 127 → B4 = 0x7F, B5 = 0x32 (checksum wraps).
- `play_req` (addr 3) and `alarm_req` in the same cycle → only one frame, with B4 = 0x63. No second frame follows.
- `alarm_req` during byte 2 of a play frame (addr 10) → the frame completes with B4 = 0x0A, B5 = 0xBD. After the gap a second frame with B4 = 0x63 starts one cycle after `busy` falls. A `play_req` during the gap produces no frame.
- `tx_done` pulses injected in IDLE, SEND and GAP → no state change and no extra `tx_start`. Check that `tx_start` is never high on two consecutive cycles.
- Assert `rst_n` low during WAIT for byte 3, with an alarm pending → all outputs return to their reset values asynchronously. After release there are no strobes until a new request arrives.
